// File: rtl/cnn_adder_tree_if.sv
// Beat/result bundle for cnn_adder_tree: operands and control strobes in, qualified result out.
// The status qualifier is a small code; zero means "no data", any other code is a valid beat.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef ICP_NUM
`define ICP_NUM 4
`endif
`ifndef PE_STATE_W
`define PE_STATE_W 2
`endif
`ifndef PE_STATE
`define PE_STATE logic [`PE_STATE_W-1:0]
`endif
`ifndef PE_INVALID
`define PE_INVALID 2'd0
`endif

interface cnn_adder_tree_if #(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int ICP_NUM  = `ICP_NUM
);
  logic                                    stall;
  `PE_STATE                                status_in;
  logic signed [ICP_NUM-1:0][DATA_WID-1:0] data_in;
  logic                                    acc_en;
  logic                                    last_in;
  logic                                    clr_ovf;
  `PE_STATE                                status_out;
  logic signed [DATA_WID-1:0]              data_out;
  logic                                    ovf_out;

  modport master (
    output stall, status_in, data_in, acc_en, last_in, clr_ovf,
    input  status_out, data_out, ovf_out
  );

  modport slave (
    input  stall, status_in, data_in, acc_en, last_in, clr_ovf,
    output status_out, data_out, ovf_out
  );
endinterface

// File: rtl/cnn_adder_tree.sv
// Pipelined signed adder tree over ICP_NUM channels with a final accumulate/saturate stage.
// Tree nodes are stored heap-style: node i sums nodes 2i and 2i+1; indices >= ICP_NUM are the inputs.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef ICP_NUM
`define ICP_NUM 4
`endif
`ifndef PE_STATE_W
`define PE_STATE_W 2
`endif
`ifndef PE_STATE
`define PE_STATE logic [`PE_STATE_W-1:0]
`endif
`ifndef PE_INVALID
`define PE_INVALID 2'd0
`endif

module cnn_adder_tree #(
  parameter int DATA_WID  = `CNN_XLEN,
  parameter int ICP_NUM   = `ICP_NUM,
  parameter int ACC_GUARD = 8,
  parameter bit SAT_EN    = 1'b1
) (
  input logic             clk,
  input logic             reset,
  cnn_adder_tree_if.slave bus
);
  localparam int LVL      = $clog2(ICP_NUM);
  localparam int TREE_WID = DATA_WID + LVL;
  localparam int ACC_WID  = TREE_WID + ACC_GUARD;

  logic signed [TREE_WID-1:0] node_q [1:ICP_NUM-1];
  logic signed [TREE_WID-1:0] node_d [1:ICP_NUM-1];
  logic signed [TREE_WID-1:0] tree   [2:2*ICP_NUM-1];
  `PE_STATE                   stat_q [1:LVL];
  `PE_STATE                   stat_d [1:LVL];
  logic [LVL:1]               acc_en_q, acc_en_d;
  logic [LVL:1]               last_q, last_d;

  logic signed [ACC_WID-1:0]  acc_q, acc_d;
  logic signed [DATA_WID-1:0] data_out_q, data_out_d;
  `PE_STATE                   status_out_q, status_out_d;
  logic                       ovf_q, ovf_d;

  logic signed [ACC_WID-1:0]  sum_ext;
  logic signed [ACC_WID-1:0]  pre;
  logic                       emit;
  logic                       out_rng;

  always_comb begin
    for (int j = 2; j < ICP_NUM; j++) tree[j] = node_q[j];
    for (int m = 0; m < ICP_NUM; m++)
      tree[ICP_NUM+m] = {{LVL{bus.data_in[m][DATA_WID-1]}}, bus.data_in[m]};
    for (int i = 1; i < ICP_NUM; i++)
      node_d[i] = bus.stall ? node_q[i] : tree[2*i] + tree[2*i+1];
  end

  // Beat qualifiers ride alongside the data so each tree level stays self-describing.
  always_comb begin
    stat_d[1]   = bus.stall ? stat_q[1]   : bus.status_in;
    acc_en_d[1] = bus.stall ? acc_en_q[1] : bus.acc_en;
    last_d[1]   = bus.stall ? last_q[1]   : bus.last_in;
    for (int k = 2; k <= LVL; k++) begin
      stat_d[k]   = bus.stall ? stat_q[k]   : stat_q[k-1];
      acc_en_d[k] = bus.stall ? acc_en_q[k] : acc_en_q[k-1];
      last_d[k]   = bus.stall ? last_q[k]   : last_q[k-1];
    end
  end

  always_comb begin
    sum_ext      = {{ACC_GUARD{node_q[1][TREE_WID-1]}}, node_q[1]};
    acc_d        = acc_q;
    data_out_d   = data_out_q;
    status_out_d = status_out_q;
    ovf_d        = ovf_q;
    pre          = sum_ext;
    emit         = 1'b0;
    if (!bus.stall) begin
      status_out_d = `PE_INVALID;
      ovf_d        = ovf_q & ~bus.clr_ovf;
      if (stat_q[LVL] != `PE_INVALID) begin
        if (!acc_en_q[LVL]) begin
          emit = 1'b1;
        end else if (!last_q[LVL]) begin
          acc_d = acc_q + sum_ext;
        end else begin
          pre   = acc_q + sum_ext;
          acc_d = '0;
          emit  = 1'b1;
        end
      end
    end
    // In range exactly when every bit from the DATA_WID sign bit upward agrees.
    out_rng = !((&pre[ACC_WID-1:DATA_WID-1]) | ~(|pre[ACC_WID-1:DATA_WID-1]));
    if (emit) begin
      status_out_d = stat_q[LVL];
      if (SAT_EN && out_rng)
        data_out_d = pre[ACC_WID-1] ? {1'b1, {(DATA_WID-1){1'b0}}}
                                    : {1'b0, {(DATA_WID-1){1'b1}}};
      else
        data_out_d = pre[DATA_WID-1:0];
      if (out_rng) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < ICP_NUM; i++) node_q[i] <= '0;
      for (int k = 1; k <= LVL; k++) stat_q[k] <= `PE_INVALID;
      acc_en_q     <= '0;
      last_q       <= '0;
      acc_q        <= '0;
      data_out_q   <= '0;
      status_out_q <= `PE_INVALID;
      ovf_q        <= 1'b0;
    end else begin
      for (int i = 1; i < ICP_NUM; i++) node_q[i] <= node_d[i];
      for (int k = 1; k <= LVL; k++) stat_q[k] <= stat_d[k];
      acc_en_q     <= acc_en_d;
      last_q       <= last_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      status_out_q <= status_out_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.status_out = status_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.ovf_out    = ovf_q;
endmodule

// File: tb/tb_cnn_adder_tree.sv
// Scoreboard bench for cnn_adder_tree: a saturating and a wrapping instance share one stimulus stream.
`ifndef PE_STATE_W
`define PE_STATE_W 2
`endif

module tb_cnn_adder_tree;
  localparam int DW  = 16;
  localparam int ICP = 4;
  localparam int LVL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_adder_tree_if #(.DATA_WID(DW), .ICP_NUM(ICP)) bus_s ();
  cnn_adder_tree_if #(.DATA_WID(DW), .ICP_NUM(ICP)) bus_w ();

  cnn_adder_tree #(.DATA_WID(DW), .ICP_NUM(ICP), .ACC_GUARD(8), .SAT_EN(1'b1))
    dut_s (.clk(clk), .reset(rst), .bus(bus_s.slave));
  cnn_adder_tree #(.DATA_WID(DW), .ICP_NUM(ICP), .ACC_GUARD(8), .SAT_EN(1'b0))
    dut_w (.clk(clk), .reset(rst), .bus(bus_w.slave));

  assign bus_w.stall     = bus_s.stall;
  assign bus_w.status_in = bus_s.status_in;
  assign bus_w.data_in   = bus_s.data_in;
  assign bus_w.acc_en    = bus_s.acc_en;
  assign bus_w.last_in   = bus_s.last_in;
  assign bus_w.clr_ovf   = bus_s.clr_ovf;

  typedef struct {
    int                   n;
    logic [1:0]           st;
    logic signed [DW-1:0] ds;
    logic signed [DW-1:0] dw;
    bit                   ov;
  } exp_t;

  exp_t    q[$];
  longint  macc;
  int      act_n;
  bit      edge_act, edge_clr;
  bit      ovf_s_m, ovf_w_m;
  int      n_chk, n_fail;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [DW-1:0] sat16(input longint v);
    if (v > 32767) return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
    return v[DW-1:0];
  endfunction

  function automatic exp_t mk(input longint v, input logic [1:0] st, input int n);
    exp_t e;
    e.n  = n;
    e.st = st;
    e.ds = sat16(v);
    e.dw = v[DW-1:0];
    e.ov = (v > 32767) || (v < -32768);
    return e;
  endfunction

  // Reference model: watches the inputs at each clock edge, applies the beat rules with plain arithmetic.
  initial begin
    macc = 0; act_n = 0; edge_act = 0; edge_clr = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        macc     = 0;
        edge_act = 0;
      end else if (bus_s.stall) begin
        edge_act = 0;
      end else begin
        longint s;
        act_n++;
        edge_act = 1;
        edge_clr = bus_s.clr_ovf;
        if (bus_s.status_in != 2'd0) begin
          s = 0;
          for (int m = 0; m < ICP; m++) s += longint'(signed'(bus_s.data_in[m]));
          if (!bus_s.acc_en) begin
            q.push_back(mk(s, bus_s.status_in, act_n + LVL));
          end else if (!bus_s.last_in) begin
            macc = macc + s;
            macc = (macc <<< 38) >>> 38;
          end else begin
            q.push_back(mk(macc + s, bus_s.status_in, act_n + LVL));
            macc = 0;
          end
        end
      end
    end
  end

  // Monitor: at every advancing edge a result is either due (must match queue head) or must be absent.
  initial begin
    ovf_s_m = 0; ovf_w_m = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ovf_s_m = 0; ovf_w_m = 0;
        chk("rst_status", bus_s.status_out, 0);
        chk("rst_data", bus_s.data_out, 0);
        chk("rst_ovf", bus_s.ovf_out, 0);
        chk("rst_status_w", bus_w.status_out, 0);
      end else begin
        if (edge_act) begin
          bit   hit;
          exp_t e;
          hit = (q.size() > 0) && (q[0].n == act_n);
          if (hit) begin
            e = q.pop_front();
            chk("status_s", bus_s.status_out, e.st);
            chk("data_sat", bus_s.data_out, e.ds);
            chk("status_w", bus_w.status_out, e.st);
            chk("data_wrap", bus_w.data_out, e.dw);
          end else begin
            chk("idle_status_s", bus_s.status_out, 0);
            chk("idle_status_w", bus_w.status_out, 0);
          end
          ovf_s_m = (ovf_s_m & ~edge_clr) | (hit && e.ov);
          ovf_w_m = (ovf_w_m & ~edge_clr) | (hit && e.ov);
        end
        chk("ovf_s", bus_s.ovf_out, ovf_s_m);
        chk("ovf_w", bus_w.ovf_out, ovf_w_m);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [1:0] st, input int a, input int b, input int c, input int d,
                      input bit acc, input bit last);
    bus_s.status_in  = st;
    bus_s.data_in[0] = a[DW-1:0];
    bus_s.data_in[1] = b[DW-1:0];
    bus_s.data_in[2] = c[DW-1:0];
    bus_s.data_in[3] = d[DW-1:0];
    bus_s.acc_en     = acc;
    bus_s.last_in    = last;
    cyc(1);
  endtask

  task automatic idle(input int n);
    bus_s.status_in = 2'd0;
    bus_s.acc_en    = 1'b0;
    bus_s.last_in   = 1'b0;
    cyc(n);
  endtask

  initial begin
    int grp;
    n_chk = 0; n_fail = 0; grp = 0;
    rst             = 1'b1;
    bus_s.stall     = 1'b0;
    bus_s.status_in = 2'd0;
    bus_s.data_in   = '0;
    bus_s.acc_en    = 1'b0;
    bus_s.last_in   = 1'b0;
    bus_s.clr_ovf   = 1'b0;
    cyc(3);
    rst = 1'b0;
    idle(2);

    beat(2'd1, 1, 2, 3, 4, 1'b0, 1'b0);
    idle(5);

    beat(2'd1, 100, 100, 100, 100, 1'b1, 1'b0);
    beat(2'd2, 100, 100, 100, 100, 1'b1, 1'b0);
    beat(2'd3, 100, 100, 100, 100, 1'b1, 1'b1);
    idle(5);

    beat(2'd1, 32767, 32767, 0, 0, 1'b0, 1'b0);
    idle(4);
    bus_s.clr_ovf = 1'b1;
    idle(1);
    bus_s.clr_ovf = 1'b0;
    idle(3);

    beat(2'd1, 5, 6, 7, 8, 1'b0, 1'b0);
    bus_s.stall = 1'b1;
    beat(2'd2, 1000, 1000, 1000, 1000, 1'b0, 1'b0);
    beat(2'd2, 1000, 1000, 1000, 1000, 1'b0, 1'b0);
    bus_s.stall = 1'b0;
    idle(6);

    beat(2'd1, 10, 10, 10, 10, 1'b1, 1'b0);
    beat(2'd1, 10, 10, 10, 10, 1'b1, 1'b0);
    bus_s.status_in = 2'd0;
    #2 rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    idle(1);
    beat(2'd1, 1, 1, 1, 1, 1'b1, 1'b1);
    idle(5);

    for (int i = 0; i < 8; i++)
      beat(2'($urandom_range(3, 1)), int'($urandom), int'($urandom), int'($urandom), int'($urandom),
           1'b0, 1'b0);
    idle(5);

    for (int i = 0; i < 300; i++) begin
      bit acc, last;
      bus_s.stall   = ($urandom_range(9, 0) == 0);
      bus_s.clr_ovf = ($urandom_range(19, 0) == 0);
      acc  = ($urandom_range(1, 0) == 1) || (grp > 0);
      last = acc && (($urandom_range(2, 0) == 0) || grp >= 5);
      if ($urandom_range(4, 0) == 0) begin
        idle(1);
      end else begin
        beat(2'($urandom_range(3, 1)), int'($urandom), int'($urandom), int'($urandom),
             int'($urandom), acc, last);
        grp = (acc && !last) ? grp + 1 : 0;
      end
    end
    bus_s.stall   = 1'b0;
    bus_s.clr_ovf = 1'b0;
    idle(8);
    chk("drain_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cnn_adder_tree.md
CNN_ADDER_TREE -- requirements
Module: cnn_adder_tree

Interface
REQ-001 Parameter DATA_WID, default `CNN_XLEN: width of each signed input operand and of data_out.
REQ-002 Parameter ICP_NUM, default `ICP_NUM: number of input channels summed per beat; a power of two, minimum 2.
REQ-003 Parameter ACC_GUARD, default 8: extra accumulator bits above the tree width.
REQ-004 Parameter SAT_EN, default 1: 1 saturates data_out to the DATA_WID signed range; 0 truncates (two's-complement wrap).
REQ-005 Derived LVL = $clog2(ICP_NUM); TREE_WID = DATA_WID+LVL; ACC_WID = TREE_WID+ACC_GUARD.
REQ-006 clk  input  1  sole clock; all state updates on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 stall  input  1  1 holds every pipeline, accumulator and output register.
REQ-009 status_in  input  PE_STATE  beat qualifier; INVALID = no data; any other value = valid beat.
REQ-010 data_in  input  signed [ICP_NUM-1:0][DATA_WID-1:0]  operands of the beat.
REQ-011 acc_en  input  1  1 = beat belongs to a multi-beat accumulation group.
REQ-012 last_in  input  1  marks the final beat of an accumulation group; ignored when acc_en=0.
REQ-013 clr_ovf  input  1  clears the sticky overflow flag.
REQ-014 status_out  output  PE_STATE  result qualifier; INVALID when no result is presented.
REQ-015 data_out  output  signed [DATA_WID-1:0]  result.
REQ-016 ovf_out  output  1  sticky flag; set when any emitted result was saturated or wrapped.

Function
REQ-017 The adder tree shall have LVL registered levels; level k sums pairs of level k-1 values, sign-extended, at TREE_WID width, so no tree overflow is possible.
REQ-018 status_in, acc_en and last_in shall travel alongside the data through every tree level.
REQ-019 A final stage after level LVL shall perform accumulation and saturation and register data_out, status_out and ovf_out; total latency from a valid beat to status_out = LVL+1 cycles when stall=0.
REQ-020 Back-to-back valid beats shall be accepted every cycle; throughput is one beat per cycle.
REQ-021 Final stage, beat with acc_en=0: data_out = sat(tree sum); status_out = the beat's status; the accumulator is not touched.
REQ-022 Final stage, beat with acc_en=1 and last_in=0: accumulator += sign-extended tree sum (ACC_WID, wrapping); status_out = INVALID; data_out holds its previous value.
REQ-023 Final stage, beat with acc_en=1 and last_in=1: data_out = sat(accumulator + tree sum); status_out = the beat's status; accumulator cleared to 0 in the same cycle.
REQ-024 Final stage, INVALID beat: status_out = INVALID; data_out and the accumulator hold.
REQ-025 sat(): with SAT_EN=1, values above 2^(DATA_WID-1)-1 clamp to that maximum and values below -2^(DATA_WID-1) clamp to that minimum; with SAT_EN=0, the low DATA_WID bits are taken.
REQ-026 ovf_out shall be set on the cycle a result is emitted whose pre-sat value lies outside the DATA_WID range; clr_ovf clears it; if set and clear occur in the same cycle, set wins.
REQ-027 stall=1 shall freeze all registers, including ovf_out and the accumulator; the beat presented on status_in/data_in that cycle is discarded; status_out keeps its held value.
REQ-028 Reset asserted mid-group shall discard the partial accumulation and all in-flight beats.

Reset
REQ-029 While reset=1, regardless of clk: all tree levels carry status INVALID; accumulator = 0; data_out = 0; status_out = INVALID; ovf_out = 0.
REQ-030 After reset deasserts, the first valid beat shall appear at status_out exactly LVL+1 cycles after it is applied.

Verification
REQ-031 Configuration DATA_WID=16, ICP_NUM=4, SAT_EN=1, acc_en=0; stimulus data_in={1,2,3,4} valid -> data_out=10 and status_out valid 3 cycles later, INVALID before and after.
REQ-032 Accumulation, same configuration; three beats of {100,100,100,100} with last_in on the third -> a single valid result of 1200; status_out INVALID for the first two beats.
REQ-033 Saturation; stimulus {32767,32767,0,0} -> data_out=32767 and ovf_out=1; with SAT_EN=0 -> data_out=-2 and ovf_out=1; clr_ovf pulse -> ovf_out=0.
REQ-034 Stall; stall=1 for 2 cycles while a beat is in flight -> result delayed by exactly 2 cycles with value unchanged, and the beat presented during the stall is dropped.
REQ-035 Reset mid-group; after two acc beats of {10,10,10,10}, assert reset, then send a last beat of {1,1,1,1} -> data_out=4.
REQ-036 Streaming; 8 consecutive valid beats -> 8 consecutive valid results in order, with no bubbles.
